// File: rtl/root_pkg.sv
// Shared definitions for the parametrised non-restoring square-root unit.
package root_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } root_state_t;

  function automatic bit width_ok(input int w);
    return (w >= 4) && ((w % 2) == 0);
  endfunction

endpackage

// File: rtl/root_nonrestoring_param_addsub.sv
// (H+2)-bit add/subtract used for both the iteration step and the final remainder correction.
module root_addsub #(
  parameter int W = 18
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  input  logic         cin,
  output logic [W-1:0] s
);

  assign s = a + (sub ? ~b : b) + {{(W-1){1'b0}}, cin};

endmodule

// File: rtl/root_nonrestoring_param.sv
// Sequential non-restoring integer square root: one root bit per clock, then a correction cycle.
module root_nonrestoring_param
  import root_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int H     = WIDTH / 2,
  localparam int CW    = $clog2(H)
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [WIDTH-1:0] d,
  input  logic             load,
  input  logic             abort,
  output logic [H-1:0]     q,
  output logic [H:0]       r,
  output logic [H:0]       q_rnd,
  output logic             busy,
  output logic             ready,
  output logic [CW-1:0]    count
);

  if (!width_ok(WIDTH)) begin : g_width_check
    $error("root_nonrestoring_param: WIDTH must be even and >= 4");
  end

  root_state_t      state;
  logic [WIDTH-1:0] dreg;
  logic [H-1:0]     root;
  logic [H+1:0]     rem;
  logic [H+1:0]     as_a, as_b, as_s, r_fix;
  logic             as_sub, as_cin;
  logic [H:0]       q_rnd_nx;

  // One adder serves ITER ({rem,d[top2]} -/+ {root,sign,1}) and FIX (rem + {root,1}).
  always_comb begin
    as_sub = 1'b0;
    as_cin = 1'b0;
    as_a   = {rem[H-1:0], dreg[WIDTH-1 -: 2]};
    as_b   = {root, rem[H+1], 1'b1};
    if (state == FIX) begin
      as_a = rem;
      as_b = {1'b0, root, 1'b1};
    end else begin
      as_sub = ~rem[H+1];
      as_cin = ~rem[H+1];
    end
    r_fix    = rem[H+1] ? as_s : rem;
    q_rnd_nx = (r_fix[H:0] > {1'b0, root}) ? ({1'b0, root} + (H+1)'(1)) : {1'b0, root};
  end

  root_addsub #(.W(H + 2)) u_addsub (
    .a   (as_a),
    .b   (as_b),
    .sub (as_sub),
    .cin (as_cin),
    .s   (as_s)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
      dreg  <= '0;
      root  <= '0;
      rem   <= '0;
      count <= '0;
      busy  <= 1'b0;
      ready <= 1'b0;
      q     <= '0;
      r     <= '0;
      q_rnd <= '0;
    end else if (abort) begin
      state <= IDLE;
      count <= '0;
      busy  <= 1'b0;
      ready <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (load) begin
            dreg  <= d;
            root  <= '0;
            rem   <= '0;
            count <= '0;
            busy  <= 1'b1;
            ready <= 1'b0;
            state <= ITER;
          end
        end
        ITER: begin
          rem  <= as_s;
          root <= {root[H-2:0], ~as_s[H+1]};
          dreg <= {dreg[WIDTH-3:0], 2'b00};
          if (count == CW'(H - 1)) begin
            count <= '0;
            state <= FIX;
          end else begin
            count <= count + CW'(1);
          end
        end
        FIX: begin
          rem   <= r_fix;
          q     <= root;
          r     <= r_fix[H:0];
          q_rnd <= q_rnd_nx;
          busy  <= 1'b0;
          ready <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
